// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge. Each AHB transfer becomes one APB SETUP + ENABLE
// access to one of three fixed-address APB slaves.
module ahb_apb_bridge (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Pselx,
  output logic        Pwrite,
  output logic        Penable,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRead     = 3'd1;
  localparam logic [2:0] StRenable  = 3'd2;
  localparam logic [2:0] StWwait    = 3'd3;
  localparam logic [2:0] StWrite    = 3'd4;
  localparam logic [2:0] StWritep   = 3'd5;
  localparam logic [2:0] StWenable  = 3'd6;
  localparam logic [2:0] StWenablep = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr1_q, addr2_q, data1_q;
  logic        hwrite_q;
  logic [2:0]  psel_q, psel_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        penable_q, penable_d;
  logic        hreadyout_q, hreadyout_d;
  logic        in_map;
  logic        valid;

  // Three 64 MiB windows starting at 0x8000_0000.
  function automatic logic [2:0] decode(input logic [31:0] a);
    logic [2:0] sel;
    sel = 3'b000;
    if (a[31:28] == 4'h8) begin
      case (a[27:26])
        2'b00:   sel = 3'b001;
        2'b01:   sel = 3'b010;
        2'b10:   sel = 3'b100;
        default: sel = 3'b000;
      endcase
    end
    return sel;
  endfunction

  assign in_map = (Haddr >= 32'h8000_0000) && (Haddr < 32'h8C00_0000);
  assign valid  = Hreadyin && Htrans[1] && in_map;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    penable_d   = 1'b0;
    hreadyout_d = 1'b1;
    unique case (state_q)
      StIdle, StRenable, StWenable: begin
        psel_d = 3'b000;
        if (valid && Hwrite) begin
          state_d = StWwait;
        end else if (valid) begin
          state_d     = StRead;
          psel_d      = decode(Haddr);
          paddr_d     = Haddr;
          pwrite_d    = 1'b0;
          hreadyout_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StWwait: begin
        state_d     = valid ? StWritep : StWrite;
        psel_d      = decode(addr1_q);
        paddr_d     = addr1_q;
        pwdata_d    = Hwdata;
        pwrite_d    = 1'b1;
        hreadyout_d = 1'b0;
      end
      StRead: begin
        state_d   = StRenable;
        penable_d = 1'b1;
      end
      StWrite: begin
        state_d   = valid ? StWenablep : StWenable;
        penable_d = 1'b1;
      end
      StWritep: begin
        state_d   = StWenablep;
        penable_d = 1'b1;
      end
      StWenablep: begin
        // The pending transfer was accepted two cycles back, so its address sits in addr2.
        psel_d      = decode(addr2_q);
        paddr_d     = addr2_q;
        hreadyout_d = 1'b0;
        if (hwrite_q) begin
          state_d  = valid ? StWritep : StWrite;
          pwdata_d = data1_q;
          pwrite_d = 1'b1;
        end else begin
          state_d  = StRead;
          pwrite_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= StIdle;
      addr1_q     <= '0;
      addr2_q     <= '0;
      data1_q     <= '0;
      hwrite_q    <= 1'b0;
      psel_q      <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr1_q     <= Haddr;
      addr2_q     <= addr1_q;
      data1_q     <= Hwdata;
      hwrite_q    <= Hwrite;
      psel_q      <= psel_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  assign Pselx     = {29'b0, psel_q};
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Pwrite    = pwrite_q;
  assign Penable   = penable_q;
  assign Hreadyout = hreadyout_q;
  assign Hresp     = 2'b00;
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge; HREADY is looped back from Hreadyout like a one-slave system.
module tb_ahb_apb_bridge;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] pselx;
  logic        pwrite;
  logic        penable;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  ahb_apb_bridge u_dut (
    .Hclk      (hclk),
    .Hresetn   (hresetn),
    .Hwrite    (hwrite),
    .Hreadyin  (hreadyin),
    .Htrans    (htrans),
    .Haddr     (haddr),
    .Hwdata    (hwdata),
    .Prdata    (prdata),
    .Hrdata    (hrdata),
    .Hreadyout (hreadyout),
    .Hresp     (hresp),
    .Pselx     (pselx),
    .Pwrite    (pwrite),
    .Penable   (penable),
    .Paddr     (paddr),
    .Pwdata    (pwdata)
  );

  assign hreadyin = hreadyout;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  logic [1:0]  ign_trans [4];
  logic [31:0] ign_addr  [4];
  logic        ign_write [4];

  initial begin
    hresetn = 1'b0;
    hwrite  = 1'b0;
    htrans  = TrIdle;
    haddr   = '0;
    hwdata  = '0;
    prdata  = '0;

    // Reset
    cyc();
    cyc();
    check_eq("rst_pselx", pselx, 32'h0);
    check_eq("rst_penable", {31'b0, penable}, 32'h0);
    check_eq("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
    check_eq("rst_hresp", {30'b0, hresp}, 32'h0);
    check_eq("rst_paddr", paddr, 32'h0);
    check_eq("rst_pwdata", pwdata, 32'h0);
    hresetn = 1'b1;
    cyc();

    // Single write
    htrans = TrNonseq;
    hwrite = 1'b1;
    haddr  = 32'h8000_0010;
    cyc();
    check_eq("wr_wwait_pselx", pselx, 32'h0);
    check_eq("wr_wwait_hready", {31'b0, hreadyout}, 32'h1);
    htrans = TrIdle;
    haddr  = 32'h0;
    hwdata = 32'hA5A5_0001;
    cyc();
    check_eq("wr_setup_pselx", pselx, 32'h1);
    check_eq("wr_setup_paddr", paddr, 32'h8000_0010);
    check_eq("wr_setup_pwrite", {31'b0, pwrite}, 32'h1);
    check_eq("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
    check_eq("wr_setup_penable", {31'b0, penable}, 32'h0);
    check_eq("wr_setup_hready", {31'b0, hreadyout}, 32'h0);
    cyc();
    check_eq("wr_en_penable", {31'b0, penable}, 32'h1);
    check_eq("wr_en_pselx", pselx, 32'h1);
    check_eq("wr_en_hready", {31'b0, hreadyout}, 32'h1);
    cyc();
    check_eq("wr_done_pselx", pselx, 32'h0);
    check_eq("wr_done_penable", {31'b0, penable}, 32'h0);
    check_eq("wr_done_paddr_hold", paddr, 32'h8000_0010);

    // Single read
    hwrite = 1'b0;
    htrans = TrNonseq;
    haddr  = 32'h8400_0004;
    prdata = 32'hDEAD_BEEF;
    cyc();
    check_eq("rd_setup_pselx", pselx, 32'h2);
    check_eq("rd_setup_paddr", paddr, 32'h8400_0004);
    check_eq("rd_setup_pwrite", {31'b0, pwrite}, 32'h0);
    check_eq("rd_setup_penable", {31'b0, penable}, 32'h0);
    check_eq("rd_setup_hready", {31'b0, hreadyout}, 32'h0);
    htrans = TrIdle;
    haddr  = 32'h0;
    cyc();
    check_eq("rd_en_penable", {31'b0, penable}, 32'h1);
    check_eq("rd_en_pselx", pselx, 32'h2);
    check_eq("rd_en_hready", {31'b0, hreadyout}, 32'h1);
    check_eq("rd_en_hrdata", hrdata, 32'hDEAD_BEEF);
    cyc();
    check_eq("rd_done_pselx", pselx, 32'h0);

    // Pipelined writes
    hwrite = 1'b1;
    htrans = TrNonseq;
    haddr  = 32'h8800_0000;
    cyc();
    check_eq("pw_wwait_pselx", pselx, 32'h0);
    htrans = TrSeq;
    haddr  = 32'h8800_0004;
    hwdata = 32'h1;
    cyc();
    check_eq("pw1_setup_pselx", pselx, 32'h4);
    check_eq("pw1_setup_paddr", paddr, 32'h8800_0000);
    check_eq("pw1_setup_pwdata", pwdata, 32'h1);
    check_eq("pw1_setup_penable", {31'b0, penable}, 32'h0);
    htrans = TrIdle;
    haddr  = 32'h0;
    hwdata = 32'h2;
    cyc();
    check_eq("pw1_en_penable", {31'b0, penable}, 32'h1);
    check_eq("pw1_en_paddr", paddr, 32'h8800_0000);
    check_eq("pw1_en_pwdata", pwdata, 32'h1);
    cyc();
    check_eq("pw2_setup_pselx", pselx, 32'h4);
    check_eq("pw2_setup_paddr", paddr, 32'h8800_0004);
    check_eq("pw2_setup_pwdata", pwdata, 32'h2);
    check_eq("pw2_setup_penable", {31'b0, penable}, 32'h0);
    check_eq("pw2_setup_pwrite", {31'b0, pwrite}, 32'h1);
    cyc();
    check_eq("pw2_en_penable", {31'b0, penable}, 32'h1);
    check_eq("pw2_en_paddr", paddr, 32'h8800_0004);
    cyc();
    check_eq("pw_done_pselx", pselx, 32'h0);
    check_eq("pw_done_penable", {31'b0, penable}, 32'h0);

    // Ignored transfers
    ign_trans[0] = TrIdle;   ign_addr[0] = 32'h8000_0000; ign_write[0] = 1'b0;
    ign_trans[1] = TrBusy;   ign_addr[1] = 32'h8000_0000; ign_write[1] = 1'b1;
    ign_trans[2] = TrNonseq; ign_addr[2] = 32'h9000_0000; ign_write[2] = 1'b0;
    ign_trans[3] = TrSeq;    ign_addr[3] = 32'h8C00_0000; ign_write[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      htrans = ign_trans[i];
      haddr  = ign_addr[i];
      hwrite = ign_write[i];
      cyc();
      cyc();
      check_eq($sformatf("ign%0d_pselx", i), pselx, 32'h0);
      check_eq($sformatf("ign%0d_hready", i), {31'b0, hreadyout}, 32'h1);
      check_eq($sformatf("ign%0d_penable", i), {31'b0, penable}, 32'h0);
    end
    htrans = TrIdle;
    cyc();

    // Top of the map still decodes
    hwrite = 1'b0;
    htrans = TrNonseq;
    haddr  = 32'h8BFF_FFFC;
    cyc();
    check_eq("edge_rd_pselx", pselx, 32'h4);
    check_eq("edge_rd_paddr", paddr, 32'h8BFF_FFFC);
    htrans = TrIdle;
    haddr  = 32'h0;
    cyc();
    cyc();

    // Reset mid-write
    hwrite = 1'b1;
    htrans = TrNonseq;
    haddr  = 32'h8000_0020;
    cyc();
    htrans = TrIdle;
    haddr  = 32'h0;
    hwdata = 32'h0000_1234;
    cyc();
    check_eq("rw_setup_pselx", pselx, 32'h1);
    hresetn = 1'b0;
    #1;
    check_eq("rw_rst_pselx", pselx, 32'h0);
    check_eq("rw_rst_paddr", paddr, 32'h0);
    check_eq("rw_rst_pwdata", pwdata, 32'h0);
    check_eq("rw_rst_pwrite", {31'b0, pwrite}, 32'h0);
    check_eq("rw_rst_hready", {31'b0, hreadyout}, 32'h1);
    cyc();
    check_eq("rw_hold_penable", {31'b0, penable}, 32'h0);
    hresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq($sformatf("rw_after%0d_penable", i), {31'b0, penable}, 32'h0);
      check_eq($sformatf("rw_after%0d_pselx", i), pselx, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
